// File: rtl/my_pkg.sv
// Shared types for the RISCV-Lite hazard controller and the forwarding-unit hookup.
package my_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_freeze;
    } hz_ctrl_o;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
        logic       rd_nz;
    } dst_track_t;

    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use_rs1,
        input logic       use_rs2,
        input logic [4:0] ex_rd,
        input logic       ex_memread
    );
        return ex_memread && (ex_rd != 5'd0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/dst_track.sv
// Two-stage EX->MEM->WB destination metadata pipeline; both stages hold when en_i is low.
module dst_track
    import my_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  dst_track_t ex_i,
    output dst_track_t mem_o,
    output dst_track_t wb_o
);

    dst_track_t mem_q;
    dst_track_t wb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (en_i) begin
            mem_q <= ex_i;
            wb_q  <= mem_q;
        end
    end

    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / branch / memory-wait hazard controller with registered MEM/WB destination tracking.
module hazard_stall_unit
    import my_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic       ex_branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_we,
    output logic       ifid_we,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       pipe_freeze,
    output logic [4:0] mem_rd,
    output logic [4:0] wb_rd,
    output logic       mem_regwrite,
    output logic       wb_regwrite,
    output logic       mem_rd_nz,
    output logic       wb_rd_nz,
    output logic       timeout_err
);

    hz_state_t  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       freeze;
    logic       hazard;
    hz_ctrl_o   ctrl;
    dst_track_t ex_dst, mem_dst, wb_dst;

    assign freeze = dmem_req && !dmem_ready;
    assign hazard = load_use_hit(id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memread);

    always_comb begin
        ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                 idex_bubble: 1'b0, pipe_freeze: 1'b0};
        if (freeze) begin
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.pipe_freeze = 1'b1;
        end else if (ex_branch_taken) begin
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if (hazard) begin
            ctrl.pc_we       = 1'b0;
            ctrl.ifid_we     = 1'b0;
            ctrl.idex_bubble = 1'b1;
        end
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_freeze = ctrl.pipe_freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (freeze) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                if (dmem_ready) begin
                    state_d = RUN;
                end else if (cnt_q == 8'(WAIT_TIMEOUT - 1)) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            TIMEOUT: begin
                if (dmem_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign timeout_err = timeout_q;

    assign ex_dst = '{rd: ex_rd, regwrite: ex_regwrite, rd_nz: (ex_rd != 5'd0)};

    dst_track u_dst_track (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!freeze),
        .ex_i  (ex_dst),
        .mem_o (mem_dst),
        .wb_o  (wb_dst)
    );

    assign mem_rd       = mem_dst.rd;
    assign mem_regwrite = mem_dst.regwrite;
    assign mem_rd_nz    = mem_dst.rd_nz;
    assign wb_rd        = wb_dst.rd;
    assign wb_regwrite  = wb_dst.regwrite;
    assign wb_rd_nz     = wb_dst.rd_nz;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: table of combinational control vectors plus hand-written multi-cycle sequences.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, ex_branch_taken;
    logic       dmem_req, dmem_ready;
    logic       pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
    logic [4:0] mem_rd, wb_rd;
    logic       mem_regwrite, wb_regwrite, mem_rd_nz, wb_rd_nz, timeout_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.WAIT_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_regwrite     (ex_regwrite),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_freeze     (pipe_freeze),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_regwrite    (mem_regwrite),
        .wb_regwrite     (wb_regwrite),
        .mem_rd_nz       (mem_rd_nz),
        .wb_rd_nz        (wb_rd_nz),
        .timeout_err     (timeout_err)
    );

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       use1, use2;
        logic [4:0] erd;
        logic       memread, branch, req, ready;
        logic       pc, ifid, flush, bubble, frz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance one rising edge; return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ctrl(input string tag, input logic pc, input logic ifid,
                              input logic fl, input logic bb, input logic fz);
        check({tag, ".pc_we"},       8'(pc_we),       8'(pc));
        check({tag, ".ifid_we"},     8'(ifid_we),     8'(ifid));
        check({tag, ".ifid_flush"},  8'(ifid_flush),  8'(fl));
        check({tag, ".idex_bubble"}, 8'(idex_bubble), 8'(bb));
        check({tag, ".pipe_freeze"}, 8'(pipe_freeze), 8'(fz));
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        //           name          rs1   rs2   u1 u2 erd   mr br rq rdy  pc if fl bb fz
        vecs[0] = '{"normal",      5'd1, 5'd2, 1, 1, 5'd5, 0, 0, 0, 0,   1, 1, 0, 0, 0};
        vecs[1] = '{"lu_rs1",      5'd5, 5'd2, 1, 0, 5'd5, 1, 0, 0, 0,   0, 0, 0, 1, 0};
        vecs[2] = '{"lu_rs2",      5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0,   0, 0, 0, 1, 0};
        vecs[3] = '{"lu_unused",   5'd5, 5'd5, 0, 0, 5'd5, 1, 0, 0, 0,   1, 1, 0, 0, 0};
        vecs[4] = '{"load_x0",     5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0,   1, 1, 0, 0, 0};
        vecs[5] = '{"br_over_lu",  5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0,   1, 1, 1, 1, 0};
        vecs[6] = '{"frz_over_br", 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 1, 0,   0, 0, 0, 0, 1};
        vecs[7] = '{"req_ready",   5'd1, 5'd2, 1, 1, 5'd9, 0, 0, 1, 1,   1, 1, 0, 0, 0};
        vecs[8] = '{"rd_mismatch", 5'd6, 5'd7, 1, 1, 5'd5, 1, 0, 0, 0,   1, 1, 0, 0, 0};
        vecs[9] = '{"branch_only", 5'd0, 5'd0, 0, 0, 5'd3, 0, 1, 0, 1,   1, 1, 1, 1, 0};

        do_reset();
        #1;
        check("rst.mem_rd",       8'(mem_rd),       8'd0);
        check("rst.wb_rd",        8'(wb_rd),        8'd0);
        check("rst.mem_regwrite", 8'(mem_regwrite), 8'd0);
        check("rst.wb_regwrite",  8'(wb_regwrite),  8'd0);
        check("rst.mem_rd_nz",    8'(mem_rd_nz),    8'd0);
        check("rst.wb_rd_nz",     8'(wb_rd_nz),     8'd0);
        check("rst.timeout_err",  8'(timeout_err),  8'd0);
        check_ctrl("rst", 1, 1, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
            id_use_rs1 = vecs[i].use1; id_use_rs2 = vecs[i].use2;
            ex_rd = vecs[i].erd; ex_memread = vecs[i].memread;
            ex_branch_taken = vecs[i].branch;
            dmem_req = vecs[i].req; dmem_ready = vecs[i].ready;
            #1;
            check_ctrl(vecs[i].name, vecs[i].pc, vecs[i].ifid, vecs[i].flush,
                       vecs[i].bubble, vecs[i].frz);
        end

        // Load-use stall lasts one cycle once the bubble clears ex_memread.
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        #1;
        check_ctrl("lu_cyc1", 0, 0, 0, 1, 0);
        step();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        check_ctrl("lu_cyc2", 1, 1, 0, 0, 0);

        // Tracker: rd=7 enters for one cycle then rd=0.
        do_reset();
        ex_rd = 5'd7; ex_regwrite = 1'b1;
        step();
        check("trk.e1.mem_rd",       8'(mem_rd),       8'd7);
        check("trk.e1.mem_rd_nz",    8'(mem_rd_nz),    8'd1);
        check("trk.e1.mem_regwrite", 8'(mem_regwrite), 8'd1);
        check("trk.e1.wb_rd",        8'(wb_rd),        8'd0);
        ex_rd = 5'd0; ex_regwrite = 1'b0;
        step();
        check("trk.e2.wb_rd",        8'(wb_rd),        8'd7);
        check("trk.e2.wb_regwrite",  8'(wb_regwrite),  8'd1);
        check("trk.e2.wb_rd_nz",     8'(wb_rd_nz),     8'd1);
        check("trk.e2.mem_rd",       8'(mem_rd),       8'd0);
        check("trk.e2.mem_rd_nz",    8'(mem_rd_nz),    8'd0);

        // Memory wait: 3 frozen cycles hold mem=0/wb=7, then ready lets rd=9 in.
        ex_rd = 5'd9; ex_regwrite = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check($sformatf("wait%0d.freeze", k), 8'(pipe_freeze), 8'd1);
            check($sformatf("wait%0d.pc_we", k),  8'(pc_we),       8'd0);
            step();
            check($sformatf("wait%0d.mem_rd", k), 8'(mem_rd), 8'd0);
            check($sformatf("wait%0d.wb_rd", k),  8'(wb_rd),  8'd7);
        end
        dmem_ready = 1'b1;
        #1;
        check("wait.rel.freeze", 8'(pipe_freeze), 8'd0);
        check("wait.rel.pc_we",  8'(pc_we),       8'd1);
        step();
        check("wait.adv.mem_rd", 8'(mem_rd), 8'd9);
        check("wait.adv.wb_rd",  8'(wb_rd),  8'd0);
        check("wait.no_timeout", 8'(timeout_err), 8'd0);

        // Timeout with WAIT_TIMEOUT=4: first low cycle is in RUN, TIMEOUT entered on the 5th edge.
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("to.edge%0d", k), 8'(timeout_err), (k >= 5) ? 8'd1 : 8'd0);
        end
        dmem_ready = 1'b1;
        step();
        check("to.sticky", 8'(timeout_err), 8'd1);
        dmem_req = 1'b0;
        step();
        check("to.sticky2", 8'(timeout_err), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("to.async_clear", 8'(timeout_err), 8'd0);
        check("to.async_mem_rd", 8'(mem_rd), 8'd0);
        #3;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard controller for the RISCV-Lite five-stage core. It sits upstream of the forwarding unit and detects load-use hazards, branch redirects and data-memory wait states. It produces the PC, IF/ID, ID/EX and EX/MEM enable, bubble and flush controls. It also carries the EX/MEM and MEM/WB destination-register metadata, registered, which the forwarding unit consumes.

## Interface
Parameters:
- WAIT_TIMEOUT, 16: maximum consecutive cycles of a data-memory wait before the sticky timeout flag sets (range 2..255).

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_regwrite  in  1  EX instruction writes the register file
- ex_memread  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- dmem_req  in  1  MEM stage is issuing a data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_we, ifid_we  out  1 each  PC / IF-ID register write enable
- ifid_flush, idex_bubble  out  1 each  clear IF/ID; load a NOP into ID/EX
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- mem_rd, wb_rd  out  5 each  destination register in MEM / WB
- mem_regwrite, wb_regwrite  out  1 each  MEM / WB instruction writes the register file
- mem_rd_nz, wb_rd_nz  out  1 each  the matching rd is non-zero
- timeout_err  out  1  sticky wait-timeout flag

## Operation
- The FSM has three states: RUN, MEM_WAIT and TIMEOUT. Reset puts it in RUN.
- RUN to MEM_WAIT when dmem_req=1 and dmem_ready=0. MEM_WAIT to RUN on dmem_ready=1. MEM_WAIT to TIMEOUT when the wait counter reaches WAIT_TIMEOUT-1 with dmem_ready still 0. TIMEOUT to RUN on dmem_ready=1.
- Freeze: pipe_freeze=1, pc_we=0 and ifid_we=0 whenever (dmem_req and not dmem_ready), in any state. A freeze suppresses the flush, bubble and load-use outputs.
- Branch, when not frozen: if ex_branch_taken=1 then ifid_flush=1 and idex_bubble=1, with pc_we=1 so the redirect target loads. A branch overrides load-use.
- Load-use, when not frozen and no branch: the hazard fires when ex_memread=1, ex_rd≠0, and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd). On a hazard, pc_we=0, ifid_we=0 and idex_bubble=1.
- Otherwise pc_we=1, ifid_we=1, and the flush, bubble and freeze outputs are 0.
- Priority, highest first: freeze, then branch, then load-use, then normal.
- Destination tracker, when not frozen, on each rising edge:
  - mem_rd←ex_rd; mem_regwrite←ex_regwrite; mem_rd_nz←(ex_rd≠0).
  - wb_* ← the mem_* values.
  - Frozen: all tracker registers hold.
- Wait counter: 8-bit. Clears in RUN and increments each MEM_WAIT cycle. It saturates and never wraps.
- timeout_err sets on entry to TIMEOUT and clears only on reset.

## Timing
- Control outputs (pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze) are combinational from the current inputs. Zero latency: a hazard is acted on in the cycle it is visible.
- Tracker outputs have one-cycle latency per stage: ex_rd appears on mem_rd after 1 edge and on wb_rd after 2 edges, absent freezes.
- Load-use costs exactly one stall cycle. The bubble makes ex_memread=0 next cycle, so the hazard does not re-detect.
- A memory wait of N cycles with dmem_ready low freezes for N cycles. The freeze releases in the cycle dmem_ready=1.
- Reset values: FSM=RUN, counter=0, timeout_err=0; mem_rd, wb_rd, mem_regwrite, wb_regwrite, mem_rd_nz and wb_rd_nz all 0. Combinational outputs then follow the inputs.
- Reset asserted mid-wait or mid-stall clears everything immediately. There is no pending-state carry-over.

## Structure
- Shared package my_pkg holds:
  - enum hz_state_t {RUN, MEM_WAIT, TIMEOUT};
  - struct hz_ctrl_o carrying pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
  - struct dst_track_t carrying rd, regwrite, rd_nz, for direct hookup to the forwarding-unit input bundle.
- One sub-module, dst_track: a two-stage enable-gated shift register of dst_track_t, with async reset.

## Test plan
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → exactly 1 cycle of pc_we=0, ifid_we=0, idex_bubble=1; next cycle (ex_memread=0) all enables are 1.
- Load to x0: the same stimulus with ex_rd=0 → no stall; pc_we=1 and idex_bubble=0.
- Branch with simultaneous load-use: ex_branch_taken=1 plus a hazard → ifid_flush=1, idex_bubble=1, pc_we=1 for 1 cycle.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles → pipe_freeze=1 for 3 cycles and mem_rd/wb_rd unchanged; on dmem_ready=1, the tracker advances on the next edge.
- Timeout with WAIT_TIMEOUT=4: dmem_ready low for 6 cycles → timeout_err rises after the 4th wait cycle and stays 1 after ready returns; rst_n low clears it to 0 asynchronously.
- Tracker pipeline: ex_rd=7 with ex_regwrite=1 for 1 cycle, then ex_rd=0 → mem_rd=7 and mem_rd_nz=1 at edge 1; wb_rd=7 and wb_regwrite=1 at edge 2.
